arbiter_main: RTL and testbench

- Parameterised request arbiter used by the issue stage.
- Selects one asserted bit of a request vector and reports it two ways: as a one-hot grant vector and as a binary index.
- Index value N means "no request"; callers use this to detect an idle or full condition.
- Drives both the instruction-select path (ready instructions) and the free-slot-select path (empty entries) of the issue queue. Grant outputs are combinational so the caller can act in the same cycle.

---
 rtl/arbiter_main_pkg.sv | 11 +
 rtl/arbiter_main_prio_enc.sv | 33 +++
 rtl/arbiter_main.sv | 80 ++++++++
 tb/tb_arbiter_main.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_main_pkg.sv
// Shared constants for the issue-queue arbiters.
//   ISSUE_Q_DEPTH : number of issue-queue entries (request lines per arbiter)
//   IDX_W         : width of an entry index, wide enough to hold NO_GRANT
//   NO_GRANT      : index value meaning "nothing selected" (idle or full)
package arbiter_main_pkg;

  localparam int ISSUE_Q_DEPTH = 16;
  localparam int IDX_W         = 5;
  localparam int NO_GRANT      = ISSUE_Q_DEPTH;

endpackage

// File: rtl/arbiter_main_prio_enc.sv
// Combinational lowest-set-bit encoder.
// Ports:
//   req    in  [N-1:0]   request vector
//   onehot out [N-1:0]   lowest set bit of req, zero when req is zero
//   index  out [IW-1:0]  binary position of that bit, N when req is zero
//   any    out           req is nonzero
module arbiter_prio_enc
  import arbiter_main_pkg::*;
#(
  parameter int N  = ISSUE_Q_DEPTH,
  parameter int IW = IDX_W
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    onehot = '0;
    index  = IW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IW'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/arbiter_main.sv
// Request arbiter for the issue stage (instruction select and free-slot select).
// Picks one set bit of ready, combinationally, either lowest-index-first or
// rotating from a pointer that advances past each accepted grant.
// Ports:
//   CLK      in               clock, only the round-robin pointer is clocked
//   RESET    in               asynchronous active-low reset
//   ready    in   [N-1:0]     request vector
//   accept   in               caller consumed the current grant this cycle
//   grant    out  [N-1:0]     one-hot grant, zero when idle
//   granted  out  [IW-1:0]    index of the grant, N when idle
//   valid    out              ready is nonzero
module arbiter_main
  import arbiter_main_pkg::*;
#(
  parameter int N           = ISSUE_Q_DEPTH,
  parameter int IW          = IDX_W,
  parameter int ROUND_ROBIN = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [N-1:0]  ready,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] granted,
  output logic          valid
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  rr_mask;
  logic [N-1:0]  masked_ready;
  logic [N-1:0]  masked_onehot;
  logic [N-1:0]  full_onehot;
  logic [IW-1:0] masked_idx;
  logic [IW-1:0] full_idx;
  logic          masked_any;
  logic          full_any;
  logic          use_masked;

  // Keep only requesters at or above the pointer; the first of those wins
  // the rotating search before any wrap-around.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < N; i++) begin
      rr_mask[i] = (IW'(i) >= ptr);
    end
  end

  assign masked_ready = ready & rr_mask;

  arbiter_prio_enc #(.N(N), .IW(IW)) u_enc_masked (
    .req    (masked_ready),
    .onehot (masked_onehot),
    .index  (masked_idx),
    .any    (masked_any)
  );

  arbiter_prio_enc #(.N(N), .IW(IW)) u_enc_full (
    .req    (ready),
    .onehot (full_onehot),
    .index  (full_idx),
    .any    (full_any)
  );

  // The unmasked search doubles as the wrap-around path in round-robin mode
  // and as the whole arbiter in fixed mode.
  assign use_masked = (ROUND_ROBIN != 0) && masked_any;
  assign grant      = use_masked ? masked_onehot : full_onehot;
  assign granted    = use_masked ? masked_idx    : full_idx;
  assign valid      = full_any;

  // The pointer stays at zero in fixed mode so accept has no visible effect.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr <= '0;
    end else if ((ROUND_ROBIN != 0) && accept && valid) begin
      ptr <= (granted == IW'(N - 1)) ? '0 : granted + 1'b1;
    end
  end

endmodule

// File: tb/tb_arbiter_main.sv
// Bench for arbiter_main: one fixed-priority and one round-robin instance share
// ready/accept; both are compared against a search model of the arbitration rules.
module tb_arbiter_main;
  import arbiter_main_pkg::*;

  localparam int N = ISSUE_Q_DEPTH;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  ready;
  logic          accept;
  logic [N-1:0]  grant_fx, grant_rr;
  logic [IDX_W-1:0] granted_fx, granted_rr;
  logic          valid_fx, valid_rr;

  int total = 0;
  int bad   = 0;
  int model_ptr = 0;

  arbiter_main #(.N(N), .IW(IDX_W), .ROUND_ROBIN(0)) dut_fx (
    .CLK     (CLK),
    .RESET   (RESET),
    .ready   (ready),
    .accept  (accept),
    .grant   (grant_fx),
    .granted (granted_fx),
    .valid   (valid_fx)
  );

  arbiter_main #(.N(N), .IW(IDX_W), .ROUND_ROBIN(1)) dut_rr (
    .CLK     (CLK),
    .RESET   (RESET),
    .ready   (ready),
    .accept  (accept),
    .grant   (grant_rr),
    .granted (granted_rr),
    .valid   (valid_rr)
  );

  always #5 CLK = ~CLK;

  // First set bit found walking upward from start, wrapping; NO_GRANT if none.
  function automatic int model_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (r[idx]) return idx;
    end
    return NO_GRANT;
  endfunction

  function automatic logic [N-1:0] model_onehot(input int g);
    logic [N-1:0] one;
    one = 1;
    return (g == NO_GRANT) ? '0 : (one << g);
  endfunction

  task automatic check_eq(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compare both instances against the model for the current inputs.
  task automatic checkOutput(input string tag);
    int gf, gr;
    gf = model_pick(ready, 0);
    gr = model_pick(ready, RESET ? model_ptr : 0);
    check_eq({tag, ".fx.granted"}, int'(granted_fx), gf);
    check_eq({tag, ".fx.grant"},   int'(grant_fx), int'(model_onehot(gf)));
    check_eq({tag, ".fx.valid"},   int'(valid_fx), int'(ready != 0));
    check_eq({tag, ".rr.granted"}, int'(granted_rr), gr);
    check_eq({tag, ".rr.grant"},   int'(grant_rr), int'(model_onehot(gr)));
    check_eq({tag, ".rr.valid"},   int'(valid_rr), int'(ready != 0));
  endtask

  // Change inputs away from the clock edge and let the combinational path settle.
  task automatic applyStimulus(input logic [N-1:0] r, input logic a);
    ready  = r;
    accept = a;
    #1;
  endtask

  // One clock edge; the model pointer advances past an accepted grant.
  task automatic clockStep();
    int g;
    logic adv;
    g   = model_pick(ready, model_ptr);
    adv = accept && (ready != 0) && RESET;
    @(posedge CLK);
    if (adv) model_ptr = (g + 1) % N;
    #2;
  endtask

  initial begin
    int exp_seq[4];
    logic [N-1:0] r;
    exp_seq = '{0, 4, 8, 0};

    // Reset with nothing requested.
    RESET = 1'b0;
    model_ptr = 0;
    applyStimulus('0, 1'b0);
    checkOutput("reset_none");
    check_eq("reset_none.granted_is_N", int'(granted_rr), NO_GRANT);
    clockStep();
    RESET = 1'b1;
    #1;
    checkOutput("released_none");
    check_eq("released.granted_is_N", int'(granted_fx), NO_GRANT);

    // Fixed-priority directed patterns (pointer still at 0).
    applyStimulus(16'hA0A0, 1'b0);
    checkOutput("fixed_A0A0");
    check_eq("fixed_A0A0.idx", int'(granted_fx), 5);
    check_eq("fixed_A0A0.onehot", int'(grant_fx), 32'h0020);
    applyStimulus(16'h8000, 1'b0);
    checkOutput("fixed_8000");
    check_eq("fixed_8000.idx", int'(granted_fx), 15);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("fixed_FFFF");
    check_eq("fixed_FFFF.idx", int'(granted_fx), 0);

    // Walking one and walking zero.
    for (int i = 0; i < N; i++) begin
      r = '0;
      r[i] = 1'b1;
      applyStimulus(r, 1'b0);
      checkOutput($sformatf("walk1_%0d", i));
      check_eq($sformatf("walk1_%0d.idx", i), int'(granted_fx), i);
    end
    for (int i = 0; i < N; i++) begin
      r = '1;
      r[i] = 1'b0;
      applyStimulus(r, 1'b0);
      checkOutput($sformatf("walk0_%0d", i));
      check_eq($sformatf("walk0_%0d.idx", i), int'(granted_fx), (i == 0) ? 1 : 0);
    end

    // Round-robin rotation over 0x0111.
    applyStimulus(16'h0111, 1'b1);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("rot_%0d", c));
      check_eq($sformatf("rot_%0d.seq", c), int'(granted_rr), exp_seq[c]);
      clockStep();
    end

    // Wrap from 15 back to 0.
    applyStimulus(16'h8001, 1'b1);
    checkOutput("wrap_pre");
    check_eq("wrap_pre.idx", int'(granted_rr), 15);
    clockStep();
    applyStimulus(16'h8001, 1'b0);
    checkOutput("wrap_post");
    check_eq("wrap_post.idx", int'(granted_rr), 0);

    // Accept while idle must leave the pointer alone.
    applyStimulus(16'h0100, 1'b1);
    clockStep();
    applyStimulus('0, 1'b1);
    clockStep();
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("idle_accept");
    check_eq("idle_accept.idx", int'(granted_rr), 9);

    // Asynchronous reset between edges with the pointer at 9.
    applyStimulus(16'h0003, 1'b0);
    checkOutput("areset_0003_pre");
    check_eq("areset_0003_pre.idx", int'(granted_rr), 0);
    applyStimulus(16'h0203, 1'b0);
    checkOutput("areset_pre");
    check_eq("areset_pre.idx", int'(granted_rr), 9);
    RESET = 1'b0;
    model_ptr = 0;
    #1;
    checkOutput("areset_now");
    check_eq("areset_now.idx", int'(granted_rr), 0);
    clockStep();
    RESET = 1'b1;
    #1;

    // Randomized traffic, mixing dense, sparse and empty request vectors.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       r = N'($urandom);
        1:       r = N'($urandom & $urandom & $urandom);
        2:       r = ($urandom_range(0, 3) == 0) ? '0 : '1;
        default: r = N'(1) << $urandom_range(0, N - 1);
      endcase
      applyStimulus(r, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand_%0d", c));
      clockStep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
